// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Register $0 is hardwired to zero, so it never produces a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle for the hazard controller: pipeline-register fields in, control and counters out.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic             branch_taken;
  logic             cnt_clr;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, branch_taken, cnt_clr,
    input  pc_write, if_id_write, id_ex_bubble, flush, fwd_a, fwd_b, state,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, branch_taken, cnt_clr,
    output pc_write, if_id_write, id_ex_bubble, flush, fwd_a, fwd_b, state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: clear beats increment, holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard control: stall/flush enables, operand forwarding, event counters.
// Build option: define HAZARD_FORWARDING_EN for load-use-only stalls plus EX/MEM and MEM/WB forwarding.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e  state_reg;
  hz_state_e  state_next;
  logic       prod_ex;
  logic       prod_mem;
  logic [4:0] id_src [2];
  logic       id_src_used [2];
  logic       src_hit [2];
  logic       hazard;
  logic [1:0] fwd_sel [2];

`ifdef HAZARD_FORWARDING_EN
  logic [4:0] ex_src [2];

  // Only a load still in EX cannot be forwarded in time.
  assign prod_ex  = ex_reg_write & ex_mem_read;
  assign prod_mem = 1'b0;

  assign ex_src[0] = ex_rs;
  assign ex_src[1] = ex_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] = (mem_reg_write && reg_match(ex_src[gi], mem_rd)) ? FWD_EXMEM :
                         (wb_reg_write  && reg_match(ex_src[gi], wb_rd))  ? FWD_MEMWB :
                                                                            FWD_RF;
  end
`else
  logic unused_nofwd;

  assign prod_ex  = ex_reg_write;
  assign prod_mem = mem_reg_write;
  assign fwd_sel[0] = FWD_RF;
  assign fwd_sel[1] = FWD_RF;
  assign unused_nofwd = ^{ex_rs, ex_rt, ex_mem_read, wb_rd, wb_reg_write};
`endif

  assign id_src[0]      = id_rs;
  assign id_src[1]      = id_rt;
  assign id_src_used[0] = 1'b1;
  assign id_src_used[1] = id_uses_rt;

  // WB producers are absent: the register file writes before it is read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_hit
    assign src_hit[gi] = id_src_used[gi] &&
                         ((prod_ex  && reg_match(id_src[gi], ex_rd)) ||
                          (prod_mem && reg_match(id_src[gi], mem_rd)));
  end

  assign hazard = (src_hit[0] | src_hit[1]) && (state_reg != FLUSH);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush        = 1'b0;
    if (reset) begin
      if (branch_taken) begin
        flush = 1'b1;
      end else if (hazard) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  assign fwd_a = reset ? fwd_sel[0] : FWD_RF;
  assign fwd_b = reset ? fwd_sel[1] : FWD_RF;

  always_comb begin
    state_next = RUN;
    if (branch_taken) begin
      state_next = FLUSH;
    end else if (hazard) begin
      state_next = STALL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hazard & ~branch_taken),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_taken),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expectations follow HAZARD_FORWARDING_EN when defined.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic       br;
    logic       e_pcw;
    logic       e_bub;
    logic       e_flush;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    logic [1:0] e_state;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs [14];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus();

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .id_uses_rt    (bus.id_uses_rt),
    .ex_rs         (bus.ex_rs),
    .ex_rt         (bus.ex_rt),
    .ex_rd         (bus.ex_rd),
    .ex_reg_write  (bus.ex_reg_write),
    .ex_mem_read   (bus.ex_mem_read),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .branch_taken  (bus.branch_taken),
    .cnt_clr       (bus.cnt_clr),
    .pc_write      (bus.pc_write),
    .if_id_write   (bus.if_id_write),
    .id_ex_bubble  (bus.id_ex_bubble),
    .flush         (bus.flush),
    .fwd_a         (bus.fwd_a),
    .fwd_b         (bus.fwd_b),
    .state         (bus.state),
    .stall_cnt     (bus.stall_cnt),
    .flush_cnt     (bus.flush_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
    bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_rd = 0;
    bus.ex_reg_write = 0; bus.ex_mem_read = 0;
    bus.mem_rd = 0; bus.mem_reg_write = 0;
    bus.wb_rd = 0; bus.wb_reg_write = 0;
    bus.branch_taken = 0; bus.cnt_clr = 0;
  endtask

  task automatic drive_load_use();
    bus.id_rs = 5'd8; bus.ex_rd = 5'd8;
    bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.id_rs = v.id_rs; bus.id_rt = v.id_rt; bus.id_uses_rt = v.uses_rt;
    bus.ex_rs = v.ex_rs; bus.ex_rt = v.ex_rt; bus.ex_rd = v.ex_rd;
    bus.ex_reg_write = v.ex_rw; bus.ex_mem_read = v.ex_mr;
    bus.mem_rd = v.mem_rd; bus.mem_reg_write = v.mem_rw;
    bus.wb_rd = v.wb_rd; bus.wb_reg_write = v.wb_rw;
    bus.branch_taken = v.br; bus.cnt_clr = 1'b0;
  endtask

  // Reset with conflicting inputs applied, so the forced outputs are really tested.
  task automatic do_reset();
    @(negedge clk);
    drive_load_use();
    bus.ex_rs = 5'd3; bus.mem_rd = 5'd3; bus.mem_reg_write = 1'b1;
    reset = 1'b0;
    #2;
    check("rst_state", 32'(bus.state), 32'(RUN));
    check("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    check("rst_flush_cnt", 32'(bus.flush_cnt), 0);
    check("rst_pc_write", 32'(bus.pc_write), 1);
    check("rst_bubble", 32'(bus.id_ex_bubble), 0);
    check("rst_fwd_a", 32'(bus.fwd_a), 32'(FWD_RF));
    $display("reset: state=%0d stall_cnt=%0d flush_cnt=%0d", bus.state, bus.stall_cnt, bus.flush_cnt);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
  endtask

  initial begin
    // id_rs id_rt ut ex_rs ex_rt ex_rd rw mr mem_rd rw wb_rd rw br | pcw bub fl fa fb state
    vecs[0]  = '{8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 2'b00, 2'b00, STALL};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00, RUN};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00, RUN};
    vecs[3]  = '{0, 8, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00, RUN};
    vecs[4]  = '{0, 8, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 2'b00, 2'b00, STALL};
    vecs[5]  = '{8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 1,  1, 0, 1, 2'b00, 2'b00, FLUSH};
    vecs[6]  = '{8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00, RUN};
    vecs[7]  = '{9, 0, 0, 9, 0, 0, 0, 0, 0, 0, 9, 1, 0,  1, 0, 0, FWD ? 2'b01 : 2'b00, 2'b00, RUN};
    vecs[8]  = '{0, 0, 0, 3, 3, 0, 0, 0, 3, 1, 3, 1, 0,  1, 0, 0, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00, RUN};
    vecs[9]  = '{0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 3, 1, 0,  1, 0, 0, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00, RUN};
    vecs[10] = '{6, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0,  FWD, !FWD, 0, 2'b00, 2'b00, FWD ? RUN : STALL};
    vecs[11] = '{0, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  FWD, !FWD, 0, 2'b00, 2'b00, FWD ? RUN : STALL};
    vecs[12] = '{6, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00, RUN};
    vecs[13] = '{0, 0, 0, 0, 4, 0, 0, 0, 4, 0, 4, 1, 0,  1, 0, 0, 2'b00, FWD ? 2'b01 : 2'b00, RUN};

    clear_inputs();
    do_reset();

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply_vec(vecs[i]);
      #1;
      check($sformatf("v%0d_pc_write", i), 32'(bus.pc_write), 32'(vecs[i].e_pcw));
      check($sformatf("v%0d_if_id_write", i), 32'(bus.if_id_write), 32'(vecs[i].e_pcw));
      check($sformatf("v%0d_bubble", i), 32'(bus.id_ex_bubble), 32'(vecs[i].e_bub));
      check($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(vecs[i].e_flush));
      check($sformatf("v%0d_fwd_a", i), 32'(bus.fwd_a), 32'(vecs[i].e_fa));
      check($sformatf("v%0d_fwd_b", i), 32'(bus.fwd_b), 32'(vecs[i].e_fb));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_state", i), 32'(bus.state), 32'(vecs[i].e_state));
      $display("vec %0d: pc_write=%0b bubble=%0b flush=%0b fwd_a=%02b fwd_b=%02b state=%0d",
               i, bus.pc_write, bus.id_ex_bubble, bus.flush, bus.fwd_a, bus.fwd_b, bus.state);
    end

    // Load-use: one stall, then lw moves on to EX/MEM.
    do_reset();
    @(negedge clk);
    drive_load_use();
    #1;
    check("lu_pc_write", 32'(bus.pc_write), 0);
    check("lu_bubble", 32'(bus.id_ex_bubble), 1);
    @(posedge clk);
    #1;
    check("lu_state", 32'(bus.state), 32'(STALL));
    check("lu_stall_cnt", 32'(bus.stall_cnt), 1);
    @(negedge clk);
    clear_inputs();
    bus.id_rs = 5'd8; bus.mem_rd = 5'd8; bus.mem_reg_write = 1'b1;
    #1;
    check("lu_next_pc_write", 32'(bus.pc_write), 32'(FWD));
    @(posedge clk);
    #1;
    check("lu_next_stall_cnt", 32'(bus.stall_cnt), FWD ? 1 : 2);
    $display("load-use: stall_cnt=%0d state=%0d", bus.stall_cnt, bus.state);

    // Branch taken beats a simultaneous load-use hazard.
    do_reset();
    @(negedge clk);
    drive_load_use();
    bus.branch_taken = 1'b1;
    #1;
    check("br_flush", 32'(bus.flush), 1);
    check("br_pc_write", 32'(bus.pc_write), 1);
    check("br_bubble", 32'(bus.id_ex_bubble), 0);
    @(posedge clk);
    #1;
    check("br_state", 32'(bus.state), 32'(FLUSH));
    check("br_flush_cnt", 32'(bus.flush_cnt), 1);
    check("br_stall_cnt", 32'(bus.stall_cnt), 0);
    $display("branch: state=%0d flush_cnt=%0d", bus.state, bus.flush_cnt);

    // add $5 then dependent sub $5: two stalls without forwarding, none with it.
    do_reset();
    @(negedge clk);
    bus.id_rs = 5'd5; bus.ex_rd = 5'd5; bus.ex_reg_write = 1'b1;
    #1;
    check("dep_c1_pc_write", 32'(bus.pc_write), 32'(FWD));
    @(negedge clk);
    clear_inputs();
    bus.id_rs = 5'd5; bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b1;
    #1;
    check("dep_c2_pc_write", 32'(bus.pc_write), 32'(FWD));
    @(negedge clk);
    clear_inputs();
    bus.id_rs = 5'd5; bus.wb_rd = 5'd5; bus.wb_reg_write = 1'b1;
    #1;
    check("dep_c3_pc_write", 32'(bus.pc_write), 1);
    @(posedge clk);
    #1;
    check("dep_stall_cnt", 32'(bus.stall_cnt), FWD ? 0 : 2);
    $display("dependency: stall_cnt=%0d", bus.stall_cnt);

    // Reset pulsed during a stall.
    @(negedge clk);
    clear_inputs();
    drive_load_use();
    @(posedge clk);
    #1;
    check("mid_pre_state", 32'(bus.state), 32'(STALL));
    #2;
    reset = 1'b0;
    #1;
    check("mid_state", 32'(bus.state), 32'(RUN));
    check("mid_stall_cnt", 32'(bus.stall_cnt), 0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    #1;
    check("mid_rel_pc_write", 32'(bus.pc_write), 1);
    @(posedge clk);
    #1;
    check("mid_rel_state", 32'(bus.state), 32'(RUN));
    check("mid_rel_stall_cnt", 32'(bus.stall_cnt), 0);
    $display("reset mid-stall: state=%0d stall_cnt=%0d", bus.state, bus.stall_cnt);

    // Saturation, then clear winning over a same-cycle stall.
    @(negedge clk);
    drive_load_use();
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 32'(bus.stall_cnt), 32'h0000_FFFE);
    repeat (5) @(posedge clk);
    #1;
    check("sat_hold", 32'(bus.stall_cnt), 32'h0000_FFFF);
    check("sat_flush_cnt", 32'(bus.flush_cnt), 0);
    $display("saturation: stall_cnt=%0h", bus.stall_cnt);
    @(negedge clk);
    bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_prio", 32'(bus.stall_cnt), 0);
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    check("clr_resume", 32'(bus.stall_cnt), 1);
    $display("clear: stall_cnt=%0d", bus.stall_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, which sets the width of the event counters.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port id_rs / id_rt, input, 5 bits each: source registers of the instruction in the IF/ID register.
REQ-005 SHALL have port id_uses_rt, input, 1 bit: rt is a source register (R-type, sw, beq).
REQ-006 SHALL have port ex_rs / ex_rt, input, 5 bits each: source registers of the instruction in the ID/EX register.
REQ-007 SHALL have port ex_rd, ex_reg_write, ex_mem_read, input, 5/1/1 bits: ID/EX destination (after the regDest mux) and its controls.
REQ-008 SHALL have port mem_rd, mem_reg_write, input, 5/1 bits: EX/MEM destination and regWrite.
REQ-009 SHALL have port wb_rd, wb_reg_write, input, 5/1 bits: MEM/WB destination and regWrite.
REQ-010 SHALL have port branch_taken, input, 1 bit: pcSrc resolved in the MEM stage.
REQ-011 SHALL have port cnt_clr, input, 1 bit: synchronous clear of both counters.
REQ-012 SHALL have port pc_write / if_id_write, output, 1 bit each: PC and IF/ID load enables.
REQ-013 SHALL have port id_ex_bubble, output, 1 bit: zero the ID/EX control bits.
REQ-014 SHALL have port flush, output, 1 bit: clear the IF/ID, ID/EX and EX/MEM control bits.
REQ-015 SHALL have port fwd_a / fwd_b, output, 2 bits each: ALU operand source, 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-016 SHALL have port state, output, 2 bits: registered FSM state.
REQ-017 SHALL have port stall_cnt / flush_cnt, output, CNT_W bits each: event counters.

Function
REQ-018 SHALL define a match as register equality with a nonzero register number; a match against register $0 never causes a hazard or a forward.
REQ-019 SHALL define hazard as a match of id_rs, or of id_rt when id_uses_rt=1, against the stall producer set (REQ-032/033).
REQ-020 SHALL drive the following combinationally when hazard=1 and branch_taken=0: pc_write=0, if_id_write=0, id_ex_bubble=1.
REQ-021 SHALL, when branch_taken=1, drive flush=1, pc_write=1, if_id_write=1 and id_ex_bubble=0; branch_taken overrides hazard.
REQ-022 SHALL otherwise drive pc_write=1, if_id_write=1, id_ex_bubble=0 and flush=0.
REQ-023 SHALL use FSM states RUN=0, STALL=1 and FLUSH=2; next state is FLUSH if branch_taken, else STALL if hazard, else RUN.
REQ-024 SHALL suppress hazard while state=FLUSH, because IF/ID then holds a flushed NOP.
REQ-025 SHALL treat the register file as write-before-read, so a match against wb_rd never stalls.
REQ-026 SHALL increment stall_cnt on each cycle with hazard=1 and branch_taken=0, and flush_cnt on each cycle with branch_taken=1.
REQ-027 SHALL saturate both counters at all-ones without wrapping.
REQ-028 SHALL give cnt_clr priority over a same-cycle increment.

Reset
REQ-029 SHALL, while reset=0, force state=RUN, stall_cnt=0 and flush_cnt=0.
REQ-030 SHALL hold the combinational outputs at their REQ-022 values during reset, with fwd_a=fwd_b=00.
REQ-031 SHALL, on reset asserted mid-stall, return to RUN immediately, with no residual stall on the first cycle after release.

Configuration
REQ-032 SHALL, with HAZARD_FORWARDING_EN defined, make the stall producer set ex_rd only when ex_mem_read=1 and ex_reg_write=1 (load-use, 1 cycle).
REQ-033 SHALL, with HAZARD_FORWARDING_EN defined, drive fwd_a/fwd_b = 10 on a match of ex_rs/ex_rt against mem_rd with mem_reg_write=1, else 01 on a match against wb_rd with wb_reg_write=1, else 00.
REQ-034 SHALL, without HAZARD_FORWARDING_EN, make the stall producer set ex_rd when ex_reg_write=1, plus mem_rd when mem_reg_write=1, and tie fwd_a=fwd_b=00.

Structure
REQ-035 SHALL place the state enum (RUN/STALL/FLUSH) and the fwd encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) in the shared package hazard_pkg.
REQ-036 SHALL implement both counters as instances of one sub-module, sat_counter (CNT_W wide, with inc, clr and async active-low reset).

Verification
REQ-037 SHALL cover: lw to $8 in ID/EX (ex_mem_read=1, ex_rd=8) with id_rs=8 -> one cycle of pc_write=0 and id_ex_bubble=1, state=STALL, stall_cnt=1; next cycle all enables 1.
REQ-038 SHALL cover: add to $3 in EX/MEM and in MEM/WB (both regWrite=1) with ex_rs=3 -> fwd_a=10, since EX/MEM wins; with the EX/MEM write removed -> fwd_a=01.
REQ-039 SHALL cover: ex_rd=0, ex_mem_read=1, id_rs=0 -> no stall, fwd=00.
REQ-040 SHALL cover: branch_taken=1 together with a load-use hazard -> flush=1, pc_write=1, no bubble; state=FLUSH next cycle; flush_cnt=1.
REQ-041 SHALL cover: counter forced to 16'hFFFF by repeated stalls -> holds 16'hFFFF; cnt_clr with a stall in the same cycle -> 0.
REQ-042 SHALL cover: without HAZARD_FORWARDING_EN, add $5 then dependent sub $5 -> exactly 2 stall cycles; reset pulsed low during a stall -> state=RUN and counters=0.
